// File: rtl/vram_pkg.sv
// Shared sizes and types for the sprite line store.
package vram_pkg;
    localparam int LINES         = 2048;
    localparam int LANES         = 16;
    localparam int PAIR_W        = 16;
    localparam int SPRITE_LINE_W = LANES * PAIR_W;
    localparam int LINE_AW       = $clog2(LINES);
    localparam int LANE_AW       = $clog2(LANES);
    localparam int WADDR_W       = LINE_AW + LANE_AW;
    localparam int RADDR_W       = LINE_AW + 1;

    typedef logic [SPRITE_LINE_W-1:0] sprite_line_t;
    typedef logic [PAIR_W-1:0]        pixel_pair_t;
endpackage

// File: rtl/vram_sprite_lane.sv
// One 16-bit column of the sprite store: 2048 x 16 simple dual-port RAM,
// synchronous read-first, no reset so it maps onto block RAM.
module vram_sprite_lane
    import vram_pkg::*;
(
    input  logic               clk,
    input  logic               we_i,
    input  logic [LINE_AW-1:0] waddr_i,
    input  pixel_pair_t        wdata_i,
    input  logic [LINE_AW-1:0] raddr_i,
    output pixel_pair_t        rdata_o
);
    pixel_pair_t mem_q [LINES];
    pixel_pair_t rdata_q;

    // Both updates are non-blocking, so a same-address read returns the old word.
    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/vram_sprite_memory.sv
// Sprite pixel store: 16-bit pair writes, full 256-bit line reads.
// Define VRAM_SPRITE_OUTREG_EN for an extra output stage (read latency 2).
module vram_sprite_memory
    import vram_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [RADDR_W-1:0] read_addr,
    output sprite_line_t       read_data,
    input  logic               write_enable,
    input  logic [WADDR_W-1:0] write_addr,
    input  pixel_pair_t        write_data
);
    logic [LANES-1:0][PAIR_W-1:0] lane_rd;
    logic                         rd_ok_q;
    sprite_line_t                 stage1;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        vram_sprite_lane u_lane (
            .clk     (clk),
            .we_i    (write_enable & rst_n & (write_addr[LANE_AW-1:0] == LANE_AW'(k))),
            .waddr_i (write_addr[WADDR_W-1:LANE_AW]),
            .wdata_i (write_data),
            .raddr_i (read_addr[LINE_AW-1:0]),
            .rdata_o (lane_rd[k])
        );
    end

    // The RAM register cannot be reset, so a resettable in-range flag gates it;
    // this gives the async clear and the out-of-range zeroing in one place.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_ok_q <= 1'b0;
        else        rd_ok_q <= ~read_addr[RADDR_W-1];
    end

    assign stage1 = rd_ok_q ? sprite_line_t'(lane_rd) : '0;

`ifdef VRAM_SPRITE_OUTREG_EN
    sprite_line_t out_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) out_q <= '0;
        else        out_q <= stage1;
    end

    assign read_data = out_q;
`else
    assign read_data = stage1;
`endif
endmodule

// File: tb/tb_vram_sprite_memory.sv
// Scoreboard bench for vram_sprite_memory: driver queues expected lines,
// monitor aligns them to read latency and compares.
module tb_vram_sprite_memory;
`ifdef VRAM_SPRITE_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic [11:0]  read_addr;
    logic [255:0] read_data;
    logic         write_enable;
    logic [14:0]  write_addr;
    logic [15:0]  write_data;

    vram_sprite_memory dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .read_addr    (read_addr),
        .read_data    (read_data),
        .write_enable (write_enable),
        .write_addr   (write_addr),
        .write_data   (write_data)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic         chk;
        logic [3:0]   tag;
        logic [11:0]  ra;
        logic [255:0] exp;
    } ent_t;

    logic [15:0] model [32768];
    ent_t        exp_q [$];
    ent_t        fly   [$];
    int          passed = 0;
    int          total  = 0;

    function automatic string tag_name(input logic [3:0] t);
        case (t)
            4'd0: return "reset";
            4'd1: return "fill";
            4'd2: return "lane_map";
            4'd3: return "collide_old";
            4'd4: return "collide_new";
            4'd5: return "out_of_range";
            4'd6: return "in_range_edge";
            4'd7: return "reset_wr_ignored";
            default: return "misc";
        endcase
    endfunction

    function automatic logic [255:0] exp_line(input logic [11:0] ra);
        logic [255:0] l;
        l = '0;
        if (!ra[11])
            for (int k = 0; k < 16; k++)
                l[16*k +: 16] = model[{ra[10:0], 4'(k)}];
        return l;
    endfunction

    task automatic check(input logic [3:0] tag, input logic [11:0] ra,
                         input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s addr=%h got=%h want=%h", tag_name(tag), ra, act, exp);
    endtask

    // One clock of stimulus; the expectation is taken before the write lands
    // in the model, which is exactly read-first ordering.
    task automatic cyc(input bit chk, input logic [3:0] tag, input logic [11:0] ra,
                       input bit we, input logic [14:0] wa, input logic [15:0] wd);
        ent_t e;
        read_addr    = ra;
        write_enable = we;
        write_addr   = wa;
        write_data   = wd;
        e.chk = chk;
        e.tag = tag;
        e.ra  = ra;
        e.exp = exp_line(ra);
        exp_q.push_back(e);
        if (we && rst_n) model[wa] = wd;
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) begin : mon_sample
        ent_t e;
        e = '0;
        if (exp_q.size() > 0) e = exp_q.pop_front();
        if (rst_n) fly.push_back(e);
        else       fly.delete();
    end

    always @(negedge clk) begin : mon_check
        ent_t e;
        if (rst_n && fly.size() >= LAT) begin
            e = fly.pop_front();
            if (e.chk) check(e.tag, e.ra, read_data, e.exp);
        end
    end

    initial begin
        logic [255:0] x5;
        for (int i = 0; i < 32768; i++) model[i] = '0;
        rst_n = 1'b0;
        read_addr = '0;
        write_enable = 1'b0;
        write_addr = '0;
        write_data = '0;
        #1;
        check(4'd0, 12'h000, read_data, 256'h0);
        repeat (3) @(posedge clk);
        #1;
        check(4'd0, 12'h000, read_data, 256'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 32768; i++)
            cyc(1'b0, 4'd1, 12'h000, 1'b1, 15'(i), 16'($urandom()));
        for (int l = 0; l < 2048; l++)
            cyc(1'b1, 4'd1, 12'(l), 1'b0, '0, '0);

        cyc(1'b0, 4'd2, 12'h000, 1'b1, 15'h0013, 16'hBEEF);
        cyc(1'b1, 4'd2, 12'h001, 1'b0, '0, '0);
        // Hand-computed spot check of the lane 3 slot after the mapping write.
        total++;
        if (model[15'h0013] === 16'hBEEF && exp_line(12'h001) ==? {192'bx, 16'hBEEF, 48'bx}) passed++;
        else $display("FAIL lane_slot got=%h want=beef", exp_line(12'h001));

        x5 = exp_line(12'h005);
        cyc(1'b1, 4'd3, 12'h005, 1'b1, 15'(5*16), 16'h1234);
        cyc(1'b1, 4'd4, 12'h005, 1'b0, '0, '0);
        total++;
        if (exp_line(12'h005) === {x5[255:16], 16'h1234}) passed++;
        else $display("FAIL collide_model got=%h want=%h", exp_line(12'h005), {x5[255:16], 16'h1234});

        cyc(1'b1, 4'd5, 12'h800, 1'b0, '0, '0);
        cyc(1'b1, 4'd6, 12'h7FF, 1'b0, '0, '0);
        cyc(1'b1, 4'd5, 12'hFFF, 1'b0, '0, '0);
        cyc(1'b1, 4'd6, 12'h000, 1'b0, '0, '0);
        cyc(1'b1, 4'd5, 12'hABC, 1'b0, '0, '0);

        // Mid-run reset: output clears at once, the write issued during reset is dropped.
        rst_n = 1'b0;
        #1;
        check(4'd0, 12'h001, read_data, 256'h0);
        cyc(1'b0, 4'd7, 12'h001, 1'b1, 15'h0013, 16'hDEAD);
        check(4'd0, 12'h001, read_data, 256'h0);
        rst_n = 1'b1;
        cyc(1'b1, 4'd7, 12'h001, 1'b0, '0, '0);
        cyc(1'b1, 4'd7, 12'h005, 1'b0, '0, '0);

        repeat (LAT + 2) cyc(1'b0, 4'd8, 12'h000, 1'b0, '0, '0);
        total++;
        if (exp_q.size() == 0) passed++;
        else $display("FAIL drain got=%0d want=0", exp_q.size());
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
